// File: rtl/vga_pwm_decode.sv
`default_nettype none
// ============================================================================
// Module      : vga_pwm_decode
// Description : Receive side of the 4-phase temporal-PWM video link. Sums four
//               6/6/6 PWM samples per channel into 24-bit RGB while sync is low.
// Revision    : 1.0  initial release
// ============================================================================
module vga_pwm_decode #(
    parameter int SYNC_DLY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        csync_en,
    input  logic        hsync,
    input  logic        csync,
    input  logic [17:0] din,
    output logic [23:0] dout,
    output logic        dout_valid,
    output logic        win_abort
);

    localparam int         c_NCH    = 3;
    localparam logic [1:0] c_PH_LST = 2'd3;

    logic                  w_s;
    logic                  w_s_d;
    logic                  w_act_d;
    logic [1:0]            r_phase;
    logic [1:0]            r_ph_q;
    logic [17:0]           r_din_q;
    logic                  r_act_q;
    logic [2:0]            r_count;
    logic [2:0]            w_cnt_nxt;
    logic [c_NCH-1:0][7:0] r_acc;
    logic [c_NCH-1:0][7:0] w_acc_nxt;
    logic [c_NCH-1:0][7:0] w_ch_out;
    logic [c_NCH-1:0]      r_all63;
    logic [c_NCH-1:0]      w_all63_nxt;
    logic                  w_win_done;
    logic                  w_win_abort;

    assign w_s = csync_en ? csync : hsync;

    // Delay line idles high so a reset never looks like an active window.
    generate
        if (SYNC_DLY == 0) begin : g_nodly
            assign w_s_d = w_s;
        end else begin : g_dly
            logic [SYNC_DLY-1:0] r_sync_dly;
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_sync_dly <= '1;
                end else begin
                    r_sync_dly[0] <= w_s;
                    for (int i = 1; i < SYNC_DLY; i++) begin
                        r_sync_dly[i] <= r_sync_dly[i-1];
                    end
                end
            end
            assign w_s_d = r_sync_dly[SYNC_DLY-1];
        end
    endgenerate

    assign w_act_d = ~w_s_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_phase <= 2'd0;
            r_din_q <= 18'd0;
            r_act_q <= 1'b0;
            r_ph_q  <= 2'd0;
        end else begin
            r_phase <= w_s_d ? 2'd0 : r_phase + 2'd1;
            r_din_q <= din;
            r_act_q <= w_act_d;
            r_ph_q  <= r_phase;
        end
    end

    // Phase 0 starts a fresh sum; the saturation flag survives only if every sample was 63.
    generate
        for (genvar g = 0; g < c_NCH; g++) begin : g_ch
            logic [5:0] w_smp;
            assign w_smp          = r_din_q[g*6 +: 6];
            assign w_acc_nxt[g]   = (r_ph_q == 2'd0) ? {2'b00, w_smp}
                                                     : r_acc[g] + {2'b00, w_smp};
            assign w_all63_nxt[g] = (w_smp == 6'd63) & ((r_ph_q == 2'd0) | r_all63[g]);
            assign w_ch_out[g]    = w_all63_nxt[g] ? 8'hFF : w_acc_nxt[g];
        end
    endgenerate

    assign w_cnt_nxt   = (r_ph_q == 2'd0) ? 3'd1 : r_count + 3'd1;
    assign w_win_done  = r_act_q & (r_ph_q == c_PH_LST);
    assign w_win_abort = r_act_q & ~w_act_d & (w_cnt_nxt != 3'd4);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc      <= '0;
            r_all63    <= '0;
            r_count    <= 3'd0;
            dout       <= 24'd0;
            dout_valid <= 1'b0;
            win_abort  <= 1'b0;
        end else begin
            dout_valid <= w_win_done;
            win_abort  <= w_win_abort;
            if (r_act_q) begin
                r_acc   <= w_acc_nxt;
                r_all63 <= w_all63_nxt;
                r_count <= w_cnt_nxt;
            end else begin
                r_count <= 3'd0;
            end
            if (w_win_done) begin
                dout <= w_ch_out;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pwm_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_pwm_decode
// Description : Directed bench for vga_pwm_decode at SYNC_DLY 0 and 2.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vga_pwm_decode;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        csync_en;
    logic        hsync;
    logic        csync;
    logic [17:0] din;
    logic [23:0] dout_w  [2];
    logic        valid_w [2];
    logic        abort_w [2];

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    vga_pwm_decode #(.SYNC_DLY(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .csync_en(csync_en), .hsync(hsync), .csync(csync),
        .din(din), .dout(dout_w[0]), .dout_valid(valid_w[0]), .win_abort(abort_w[0])
    );

    vga_pwm_decode #(.SYNC_DLY(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .csync_en(csync_en), .hsync(hsync), .csync(csync),
        .din(din), .dout(dout_w[1]), .dout_valid(valid_w[1]), .win_abort(abort_w[1])
    );

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] pk(input int r, input int g, input int b);
        return {r[5:0], g[5:0], b[5:0]};
    endfunction

    // Value of a completed window: plain per-channel sum, 0xFF when all four were 63.
    function automatic logic [23:0] wval(input logic [17:0] a, input logic [17:0] b,
                                         input logic [17:0] c, input logic [17:0] d);
        logic [17:0] s [4];
        logic [23:0] r;
        int          sum;
        bit          all;
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            sum = 0;
            all = 1'b1;
            for (int k = 0; k < 4; k++) begin
                sum += int'(s[k][ch*6 +: 6]);
                if (s[k][ch*6 +: 6] != 6'd63) all = 1'b0;
            end
            r[ch*8 +: 8] = all ? 8'hFF : 8'(sum);
        end
        return r;
    endfunction

    // Encoder: 4*base+frac over four phases, inputs 0xFC..0xFF clamp to base 63.
    function automatic logic [17:0] enc(input logic [23:0] v, input int p);
        logic [17:0] o;
        int c, base, frac;
        o = '0;
        for (int ch = 0; ch < 3; ch++) begin
            c = int'(v[ch*8 +: 8]);
            if (c >= 252) begin base = 63; frac = 0; end
            else begin base = c / 4; frac = c % 4; end
            o[ch*6 +: 6] = 6'(base + ((p < frac) ? 1 : 0));
        end
        return o;
    endfunction

    function automatic logic [23:0] clampv(input logic [23:0] v);
        logic [23:0] r;
        for (int ch = 0; ch < 3; ch++) begin
            r[ch*8 +: 8] = (v[ch*8 +: 8] >= 8'hFC) ? 8'hFF : v[ch*8 +: 8];
        end
        return r;
    endfunction

    // ---------------- model: runs of delayed-low sync cut into 4-sample windows
    bit          low_h   [2][8192];
    int          run_len [2];
    logic [17:0] win     [2][4];
    bit          pend_v  [2];
    logic [23:0] pend_d  [2];
    logic [23:0] e_dout  [2];
    bit          e_valid [2];
    bit          e_abort [2];
    int          md;
    bit          sd_low;

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            md = (i == 0) ? 0 : 2;
            if (cyc < 8192) low_h[i][cyc] = ~(csync_en ? csync : hsync);
            if (!reset_n) begin
                for (int j = 0; j < md; j++) low_h[i][cyc-j] = 1'b0;
                run_len[i] = 0;
                pend_v[i]  = 1'b0;
                e_dout[i]  = '0;
                e_valid[i] = 1'b0;
                e_abort[i] = 1'b0;
            end else begin
                e_valid[i] = pend_v[i];
                if (pend_v[i]) e_dout[i] = pend_d[i];
                pend_v[i]  = 1'b0;
                e_abort[i] = 1'b0;
                sd_low = (cyc > md && cyc < 8192) ? low_h[i][cyc-md] : 1'b0;
                if (sd_low) begin
                    win[i][run_len[i] % 4] = din;
                    run_len[i]++;
                    if (run_len[i] % 4 == 0) begin
                        pend_v[i] = 1'b1;
                        pend_d[i] = wval(win[i][0], win[i][1], win[i][2], win[i][3]);
                    end
                end else begin
                    e_abort[i] = (run_len[i] % 4 != 0);
                    run_len[i] = 0;
                end
            end
        end
    end

    // ---------------- compare process and strobe bookkeeping
    int nv [2];
    int na [2];
    int fv [2];
    int fa [2];

    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d_valid", i), 24'(valid_w[i]), 24'(e_valid[i]));
            chk($sformatf("dut%0d_abort", i), 24'(abort_w[i]), 24'(e_abort[i]));
            chk($sformatf("dut%0d_dout", i), dout_w[i], e_dout[i]);
            if (valid_w[i] === 1'b1) begin nv[i]++; if (fv[i] < 0) fv[i] = cyc; end
            if (abort_w[i] === 1'b1) begin na[i]++; if (fa[i] < 0) fa[i] = cyc; end
        end
    end

    // ---------------- stimulus
    logic [17:0] dq [$];
    int          last_samp;

    task automatic clr();
        for (int i = 0; i < 2; i++) begin nv[i] = 0; na[i] = 0; fv[i] = -1; fa[i] = -1; end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hsync = 1'b1; csync = 1'b1; csync_en = 1'b0; din = '0;
        end
    endtask

    // Sync low for n cycles; queued samples start pre cycles after the sync edge.
    task automatic run_win(input int n, input int pre, input bit use_cs);
        logic [17:0] d;
        bit          lo;
        clr();
        for (int i = 0; i < n + pre; i++) begin
            d  = (i >= pre && i - pre < dq.size()) ? dq[i-pre] : 18'd0;
            lo = (i < n);
            @(negedge clk);
            csync_en = use_cs;
            din      = d;
            if (use_cs) begin csync = ~lo; hsync = i[0]; end
            else begin hsync = ~lo; csync = 1'b1; end
            if (i - pre == dq.size() - 1) last_samp = cyc;
        end
        idle(6);
    endtask

    logic [23:0] rv;
    logic [23:0] lb [3];

    initial begin
        reset_n = 1'b0; hsync = 1'b1; csync = 1'b1; csync_en = 1'b0; din = '0;
        clr();
        repeat (3) @(negedge clk);
        chk("rst_dout", dout_w[0], 24'h0);
        chk("rst_valid", 24'(valid_w[1]), 24'h0);
        reset_n = 1'b1;
        idle(4);

        // 1: four samples of 0x20 per channel
        dq = '{18'h20820, 18'h20820, 18'h20820, 18'h20820};
        run_win(4, 0, 1'b0);
        chk("t1_dout", dout_w[0], 24'h808080);
        chk("t1_model", e_dout[0], 24'h808080);
        chk("t1_nvalid", 24'(nv[0]), 24'd1);
        chk("t1_nabort", 24'(na[0]), 24'd0);
        chk("t1_latency", 24'(fv[0] - last_samp), 24'd2);

        // 2: mixed fractions, then encoder loopback at SYNC_DLY=2
        dq = '{pk(33, 17, 0), pk(32, 17, 0), pk(32, 17, 0), pk(32, 16, 0)};
        run_win(4, 0, 1'b0);
        chk("t2_dout", dout_w[0], 24'h814300);
        rv = 24'($urandom);
        lb = '{rv, 24'hFD7B02, 24'hFBFC03};
        for (int v = 0; v < 3; v++) begin
            dq = '{enc(lb[v], 0), enc(lb[v], 1), enc(lb[v], 2), enc(lb[v], 3)};
            run_win(4, 2, 1'b0);
            chk($sformatf("t2_loop%0d", v), dout_w[1], clampv(lb[v]));
        end

        // 3: saturation and an illegal near-saturated pattern
        dq = '{pk(63, 63, 63), pk(63, 63, 63), pk(63, 63, 63), pk(63, 63, 63)};
        run_win(4, 0, 1'b0);
        chk("t3_sat", dout_w[0], 24'hFFFFFF);
        dq = '{pk(63, 63, 63), pk(63, 63, 63), pk(63, 63, 63), pk(62, 63, 63)};
        run_win(4, 0, 1'b0);
        chk("t3_fb", dout_w[0], 24'hFBFFFF);

        // 4: six-cycle window -> one strobe then one abort
        dq = '{pk(1, 2, 3), pk(1, 2, 3), pk(1, 2, 3), pk(1, 2, 3), pk(9, 9, 9), pk(9, 9, 9)};
        run_win(6, 0, 1'b0);
        chk("t4_nvalid", 24'(nv[0]), 24'd1);
        chk("t4_nabort", 24'(na[0]), 24'd1);
        chk("t4_abort_lat", 24'(fa[0] - last_samp), 24'd2);
        chk("t4_dout", dout_w[0], 24'h04080C);

        // 5: composite sync qualifies, hsync toggles
        dq = '{pk(5, 5, 5), pk(5, 5, 5), pk(5, 5, 5), pk(5, 5, 5),
               pk(7, 0, 1), pk(7, 0, 1), pk(7, 0, 1), pk(7, 0, 1)};
        run_win(8, 0, 1'b1);
        chk("t5_nvalid", 24'(nv[0]), 24'd2);
        chk("t5_nabort", 24'(na[0]), 24'd0);
        chk("t5_dout", dout_w[0], 24'h1C0004);

        // 6: reset on the 3rd sample of a window
        clr();
        @(negedge clk); hsync = 1'b0; din = pk(10, 10, 10);
        @(negedge clk); din = pk(10, 10, 10);
        @(negedge clk); din = pk(10, 10, 10); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1; hsync = 1'b1; din = '0;
        idle(6);
        chk("t6_dout0", dout_w[0], 24'h0);
        chk("t6_dout2", dout_w[1], 24'h0);
        chk("t6_nvalid", 24'(nv[0] + nv[1]), 24'd0);
        chk("t6_nabort", 24'(na[0] + na[1]), 24'd0);
        dq = '{pk(63, 1, 63), pk(0, 2, 63), pk(21, 3, 63), pk(42, 4, 63)};
        run_win(4, 0, 1'b0);
        chk("t6_dout", dout_w[0], 24'h7E0AFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
